// File: rtl/ap_txn_sequencer_pkg.sv
// Shared types and helpers for the ap_ctrl_chain transaction sequencer.
// State encoding, default widths and the wrap-safe latency subtraction.
package ap_txn_seq_pkg;

  localparam int DEF_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  // Low bits of the difference are exact modulo any width up to 32.
  function automatic logic [31:0] lat_of(
    input logic [31:0] now,
    input logic [31:0] was
  );
    return now - was;
  endfunction

endpackage

// File: rtl/ap_txn_sequencer_if.sv
// Block-level ap_ctrl_chain handshake between sequencer and HLS kernel.
// The sequencer is master: it drives start and continue.
interface ap_txn_sequencer_if;

  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (
    output ap_start,
    output ap_continue,
    input  ap_ready,
    input  ap_done
  );

  modport slave (
    input  ap_start,
    input  ap_continue,
    output ap_ready,
    output ap_done
  );

endinterface

// File: rtl/ap_txn_sequencer_ts_fifo.sv
// Issue-timestamp FIFO; its fill level doubles as the outstanding count.
// Same-cycle push and pop are both honoured.
module ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/ap_txn_sequencer.sv
// Drives an HLS kernel's ap_ctrl_chain port: issues N transactions,
// caps in-flight work, tracks latency min/max and a watchdog.
module ap_txn_sequencer
  import ap_txn_seq_pkg::*;
#(
  parameter int CNT_W   = DEF_W,
  parameter int MAX_OUT = 4,
  parameter int TS_W    = DEF_W,
  parameter int TO_W    = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_num_txn,
  input  logic [TO_W-1:0]   cfg_timeout,
  input  logic              sink_ready,
  ap_txn_sequencer_if.master ap,
  output logic              busy,
  output logic              all_done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  txn_issued,
  output logic [CNT_W-1:0]  txn_done,
  output logic [TS_W-1:0]   lat_min,
  output logic [TS_W-1:0]   lat_max
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUT);

  state_t            state;
  state_t            state_n;
  logic [TS_W-1:0]   ts;
  logic [CNT_W-1:0]  num_q;
  logic [TO_W-1:0]   to_q;
  logic [TO_W-1:0]   idle_cnt;
  logic [OW-1:0]     outstanding;
  logic [TS_W-1:0]   head;
  logic [TS_W-1:0]   lat;
  logic              start_c;
  logic              cont_c;
  logic              issue;
  logic              cmpl;
  logic              launch;
  logic              go;
  logic              last_iss;

  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign all_done = (state == S_DONE);

  assign start_c = (state == S_RUN)
                 && (txn_issued < num_q)
                 && (outstanding < OMAX);
  assign cont_c  = busy && sink_ready;

  assign ap.ap_start    = start_c;
  assign ap.ap_continue = cont_c;

  assign issue  = start_c && ap.ap_ready;
  assign cmpl   = ap.ap_done && cont_c && (outstanding != '0);
  assign launch = cfg_start
               && ((state == S_IDLE) || (state == S_ERR));
  assign go     = launch && (cfg_num_txn != '0);

  assign last_iss = (txn_issued + CNT_W'(1)) == num_q;
  assign lat      = TS_W'(lat_of(32'(ts), 32'(head)));

  ts_fifo #(
    .DEPTH (MAX_OUT),
    .W     (TS_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (issue),
    .din   (ts),
    .pop   (cmpl),
    .dout  (head),
    .level (outstanding)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_ERR: begin
        if (launch) state_n = go ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (issue && last_iss) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (txn_done == num_q) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Watchdog overrides any progress made in the expiring cycle.
    if (busy && (to_q != '0) && (idle_cnt == to_q))
      state_n = S_ERR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts          <= '0;
      num_q       <= '0;
      to_q        <= '0;
      idle_cnt    <= '0;
      txn_issued  <= '0;
      txn_done    <= '0;
      lat_min     <= '1;
      lat_max     <= '0;
      timeout_err <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (launch) begin
        num_q <= cfg_num_txn;
        to_q  <= cfg_timeout;
      end
      if (go || issue || cmpl) idle_cnt <= '0;
      else if (busy)           idle_cnt <= idle_cnt + 1'b1;
      if (state_n == S_ERR) timeout_err <= 1'b1;
      else if (go)          timeout_err <= 1'b0;
      if (go) begin
        txn_issued <= '0;
        txn_done   <= '0;
        lat_min    <= '1;
        lat_max    <= '0;
      end else begin
        if (issue) txn_issued <= txn_issued + 1'b1;
        if (cmpl) begin
          txn_done <= txn_done + 1'b1;
          if (lat < lat_min) lat_min <= lat;
          if (lat > lat_max) lat_max <= lat;
        end
      end
    end
  end

endmodule

// File: tb/tb_ap_txn_sequencer.sv
// Directed bench for ap_txn_sequencer with an in-order kernel model
// of fixed latency; vector table plus hand-built corner sequences.
module tb_ap_txn_sequencer;

  localparam int CNT_W   = 16;
  localparam int TS_W    = 16;
  localparam int TO_W    = 20;
  localparam int MAX_OUT = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_start = 1'b0;
  logic [CNT_W-1:0] cfg_num_txn = '0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic             sink_ready = 1'b1;
  logic             busy;
  logic             all_done;
  logic             timeout_err;
  logic [CNT_W-1:0] txn_issued;
  logic [CNT_W-1:0] txn_done;
  logic [TS_W-1:0]  lat_min;
  logic [TS_W-1:0]  lat_max;

  ap_txn_sequencer_if ap_bus ();

  ap_txn_sequencer #(
    .CNT_W   (CNT_W),
    .MAX_OUT (MAX_OUT),
    .TS_W    (TS_W),
    .TO_W    (TO_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_start   (cfg_start),
    .cfg_num_txn (cfg_num_txn),
    .cfg_timeout (cfg_timeout),
    .sink_ready  (sink_ready),
    .ap          (ap_bus),
    .busy        (busy),
    .all_done    (all_done),
    .timeout_err (timeout_err),
    .txn_issued  (txn_issued),
    .txn_done    (txn_done),
    .lat_min     (lat_min),
    .lat_max     (lat_max)
  );

  always #5 clock = ~clock;

  typedef struct {
    int num;
    int lat;
    int e_lmin;
    int e_lmax;
    int e_maxout;
  } vec_t;

  vec_t vt [5];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int maxout = 0;
  int full_start = 0;
  int k_lat = 1;
  bit k_accept = 1'b0;
  int kq [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Observe the pre-edge handshake at negedge, then drive the kernel.
  task automatic tick();
    @(negedge clock);
    if (all_done) pulses++;
    if (ap_bus.ap_start && kq.size() >= MAX_OUT) full_start++;
    if (ap_bus.ap_done && ap_bus.ap_continue && kq.size() > 0)
      void'(kq.pop_front());
    if (ap_bus.ap_start && ap_bus.ap_ready) kq.push_back(cyc);
    if (kq.size() > maxout) maxout = kq.size();
    @(posedge clock);
    #1;
    cyc++;
    ap_bus.ap_ready = k_accept;
    ap_bus.ap_done  = 1'b0;
    if (kq.size() > 0)
      ap_bus.ap_done = (cyc - kq[0]) >= k_lat;
  endtask

  task automatic launch(input int num, input int to);
    cfg_num_txn = CNT_W'(num);
    cfg_timeout = TO_W'(to);
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int p0;
    int n;
    p0 = pulses;
    n  = 0;
    while (pulses == p0 && n < budget) begin
      tick();
      n++;
    end
    if (pulses == p0) begin
      total++;
      bad++;
      $display("FAIL %s: no all_done within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    int p0;
    vt[0] = '{num: 1, lat: 5,  e_lmin: 5,  e_lmax: 5,  e_maxout: 1};
    vt[1] = '{num: 8, lat: 10, e_lmin: 10, e_lmax: 10, e_maxout: 4};
    vt[2] = '{num: 3, lat: 1,  e_lmin: 1,  e_lmax: 1,  e_maxout: 1};
    vt[3] = '{num: 5, lat: 7,  e_lmin: 7,  e_lmax: 7,  e_maxout: 4};
    vt[4] = '{num: 2, lat: 3,  e_lmin: 3,  e_lmax: 3,  e_maxout: 2};

    ap_bus.ap_ready = 1'b0;
    ap_bus.ap_done  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_flags",
        {60'd0, busy, all_done, timeout_err, ap_bus.ap_start}, 64'd0);
    chk("rst_cont", ap_bus.ap_continue, 0);
    chk("rst_lat_min", lat_min, 16'hFFFF);
    reset = 1'b0;
    tick();
    chk("idle_issued", txn_issued, 0);
    chk("idle_lat_max", lat_max, 0);

    foreach (vt[i]) begin
      k_lat      = vt[i].lat;
      k_accept   = 1'b1;
      maxout     = 0;
      full_start = 0;
      p0         = pulses;
      launch(vt[i].num, 0);
      wait_done($sformatf("v%0d_wait", i), 500);
      repeat (3) tick();
      chk($sformatf("v%0d_issued", i), txn_issued, vt[i].num);
      chk($sformatf("v%0d_done", i), txn_done, vt[i].num);
      chk($sformatf("v%0d_lmin", i), lat_min, vt[i].e_lmin);
      chk($sformatf("v%0d_lmax", i), lat_max, vt[i].e_lmax);
      chk($sformatf("v%0d_pulse", i), pulses - p0, 1);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_maxout", i), maxout, vt[i].e_maxout);
      chk($sformatf("v%0d_fullstart", i), full_start, 0);
    end

    // Backpressure: results stall 20 cycles, latency absorbs the stall.
    k_lat      = 2;
    sink_ready = 1'b0;
    launch(3, 0);
    repeat (20) tick();
    chk("bp_done_held", txn_done, 0);
    chk("bp_cont_low", ap_bus.ap_continue, 0);
    chk("bp_issued", txn_issued, 3);
    sink_ready = 1'b1;
    wait_done("bp_wait", 100);
    repeat (2) tick();
    chk("bp_done", txn_done, 3);
    chk("bp_lmin", lat_min, 20);
    chk("bp_lmax", lat_max, 20);

    // Issue and completion in the same cycle at two in flight.
    k_lat = 2;
    launch(4, 0);
    repeat (2) tick();
    chk("sc_out_r2", dut.outstanding, 2);
    tick();
    chk("sc_out_r3", dut.outstanding, 2);
    tick();
    chk("sc_out_r4", dut.outstanding, 2);
    wait_done("sc_wait", 100);
    repeat (2) tick();
    chk("sc_lmin", lat_min, 2);
    chk("sc_lmax", lat_max, 2);
    chk("sc_done", txn_done, 4);

    // Watchdog: kernel never accepts.
    k_accept = 1'b0;
    launch(2, 50);
    chk("wd_start_r0", ap_bus.ap_start, 1);
    repeat (50) tick();
    chk("wd_busy_r50", busy, 1);
    chk("wd_err_r50", timeout_err, 0);
    tick();
    chk("wd_err_r51", timeout_err, 1);
    chk("wd_busy_r51", busy, 0);
    chk("wd_start_r51", ap_bus.ap_start, 0);
    k_accept = 1'b1;
    k_lat    = 3;
    p0       = pulses;
    launch(1, 0);
    chk("wd_clear", timeout_err, 0);
    chk("wd_rerun_busy", busy, 1);
    wait_done("wd_wait", 100);
    repeat (2) tick();
    chk("wd_rerun_lat", lat_min, 3);
    chk("wd_rerun_pulse", pulses - p0, 1);

    // Zero-length run goes straight to DONE.
    p0 = pulses;
    launch(0, 0);
    chk("z_all_done", all_done, 1);
    chk("z_start", ap_bus.ap_start, 0);
    tick();
    chk("z_pulse_end", all_done, 0);
    chk("z_pulse_cnt", pulses - p0, 1);
    chk("z_held_issued", txn_issued, 1);

    // Asynchronous reset in the middle of a run.
    k_lat = 10;
    launch(8, 0);
    repeat (3) tick();
    chk("mr_issued", txn_issued, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_flags",
        {59'd0, busy, all_done, timeout_err,
         ap_bus.ap_start, ap_bus.ap_continue}, 64'd0);
    chk("mr_issued_rst", txn_issued, 0);
    chk("mr_lat_min", lat_min, 16'hFFFF);
    chk("mr_out", dut.outstanding, 0);
    kq.delete();
    ap_bus.ap_done = 1'b0;
    k_accept = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ap_txn_sequencer.md
Name: ap_txn_sequencer

Overview:
- Drives the block-level ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue) of an HLS kernel, e.g. the uniform random generator top.
- Issues a programmed number of transactions and caps the number in flight.
- Applies downstream backpressure through ap_continue.
- Reports per-transaction latency min/max and raises a watchdog timeout.
- Sits between the test/host control logic and the kernel's control ports.

Parameters:
- CNT_W, 16, width of transaction counts.
- MAX_OUT, 4, maximum outstanding transactions (issued but not completed); power of two, 1 to 16.
- TS_W, 16, width of the free-running timestamp and of latency values.
- TO_W, 20, width of the watchdog timeout.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse that launches a run.
- cfg_num_txn  in  CNT_W  transactions to issue; sampled on cfg_start.
- cfg_timeout  in  TO_W  idle-cycle limit; 0 disables the watchdog; sampled on cfg_start.
- sink_ready  in  1  downstream can accept a result.
- ap_start  out  1  kernel start.
- ap_ready  in  1  kernel accepted the start.
- ap_done  in  1  kernel result valid.
- ap_continue  out  1  result consumed.
- busy  out  1  state is RUN or DRAIN.
- all_done  out  1  one-cycle pulse when a run completes.
- timeout_err  out  1  sticky watchdog flag.
- txn_issued  out  CNT_W  issue count for the current run.
- txn_done  out  CNT_W  completion count for the current run.
- lat_min  out  TS_W  minimum latency this run.
- lat_max  out  TS_W  maximum latency this run.

Behaviour:
- Reset values: all outputs 0, except lat_min = all ones. FSM in IDLE, FIFO empty, outstanding = 0, timestamp = 0.
- Timestamp counter: free-running, increments every cycle, wraps modulo 2^TS_W.
- Issue event: ap_start & ap_ready. Completion event: ap_done & ap_continue & (outstanding > 0). ap_done while outstanding = 0 is ignored.
- outstanding: +1 on issue, -1 on completion. Unchanged when both occur in the same cycle.
- States:
  - IDLE: ap_start = 0, ap_continue = 0.
    - On cfg_start with cfg_num_txn = 0: go to DONE.
    - On cfg_start with cfg_num_txn > 0: go to RUN, and clear counters, lat_min/lat_max and timeout_err.
    - cfg_start in any other state is ignored, except in ERR.
  - RUN: ap_continue = sink_ready.
    - ap_start rises when txn_issued < num and outstanding < MAX_OUT.
    - Once high, ap_start holds until ap_ready, regardless of the limit.
    - Go to DRAIN on the issue event that makes txn_issued = num.
  - DRAIN: ap_start = 0, ap_continue = sink_ready. Go to DONE when txn_done = num.
  - DONE: all_done = 1 for exactly one cycle, then IDLE. Counters and latency outputs hold.
  - ERR: ap_start = 0, ap_continue = 0, timeout_err = 1. Leaves only on cfg_start, which behaves as the IDLE case.
- Latency:
  - On issue, push the timestamp into the FIFO.
  - On completion, pop the FIFO; lat = now - popped, modulo 2^TS_W. The oldest entry pairs with the oldest completion (in-order kernel).
  - lat_min/lat_max update in the cycle after completion (1-cycle latency).
  - Push and pop in the same cycle are both legal; the FIFO is never pushed when full, since outstanding bounds occupancy.
- Watchdog:
  - Idle counter is cleared on any issue or completion event, and on entering RUN.
  - It increments otherwise in RUN/DRAIN.
  - When cfg_timeout != 0 and the counter reaches cfg_timeout, go to ERR next cycle.
  - sink_ready = 0 still counts as idle.
- Reset mid-run: immediate return to the reset state. The kernel is not drained.

Decomposition:
- Package ap_txn_seq_pkg: state enum (IDLE, RUN, DRAIN, DONE, ERR), a default-width localparam, and a latency-compute function.
- Sub-module ts_fifo: synchronous FIFO, depth MAX_OUT, width TS_W, pointer wrap, simultaneous push/pop.

Test Plan:
- Single transaction (num = 1), kernel done 5 cycles after ap_ready, sink_ready = 1 → txn_issued = 1, txn_done = 1, lat_min = lat_max = 5, all_done pulses once.
- num = 8, kernel accepts every cycle, latency 10, MAX_OUT = 4 → ap_start low while outstanding = 4, outstanding never exceeds 4, lat_min = lat_max = 10, all_done after the 8th completion.
- Backpressure, num = 3: hold sink_ready = 0 for 20 cycles while ap_done = 1 → ap_continue = 0, txn_done stays 0; release → three completions, latencies include the stall.
- Same-cycle issue and completion at outstanding = 2 → outstanding stays 2, FIFO occupancy stays 2, pairing correct.
- Watchdog: cfg_timeout = 50, kernel never asserts ap_ready → ERR at cycle 51 after entering RUN, timeout_err = 1, ap_start = 0; next cfg_start clears it and restarts.
- cfg_num_txn = 0 → all_done one cycle after cfg_start, ap_start never asserted. Then a reset asserted mid-run (num = 8, 3 issued) → all outputs return to reset values asynchronously.
